// File: rtl/io_seq_pkg.sv
// Shared types and defaults for the I/O lane bring-up/tear-down sequencer.
package io_seq_pkg;

    localparam int unsigned DEF_LANES  = 3;
    localparam int unsigned DEF_SETTLE = 4;
    localparam int unsigned DEF_FILL   = 2;
    localparam int unsigned DEF_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        UP_SETTLE,
        UP_FILL,
        DN_DRAIN,
        DN_SETTLE
    } state_e;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_e;

    // base < n and off < n, so one conditional subtract is a full wrap
    function automatic int unsigned wrap_idx(
        input int unsigned base,
        input int unsigned off,
        input int unsigned n
    );
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/io_lane_sequencer_rr_pick.sv
// Round-robin first-one search over the pending-lane vector, starting at rr.
module rr_pick
    import io_seq_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned IDX_W = 2
) (
    input  logic [LANES-1:0] pend_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            cand = IDX_W'(wrap_idx(32'(rr_i), i, LANES));
            if (!valid_o && pend_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/io_lane_sequencer.sv
// Per-lane sequencer: I_BUF -> I_DDR -> O_BUFT_DS on the way up, reverse on
// the way down, one lane at a time under round-robin arbitration.
module io_lane_sequencer
    import io_seq_pkg::*;
#(
    parameter int unsigned LANES         = DEF_LANES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE,
    parameter int unsigned FILL_CYCLES   = DEF_FILL,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic [LANES-1:0] lane_req,
    output logic             gbuf_en,
    output logic [LANES-1:0] ibuf_en,
    output logic [LANES-1:0] iddr_en,
    output logic [LANES-1:0] obuft_t,
    output logic [LANES-1:0] lane_up,
    output logic             busy
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] lane_q;
    logic             gbuf_q;
    logic [LANES-1:0] ibuf_q;
    logic [LANES-1:0] iddr_q;
    logic [LANES-1:0] obuft_q;

    logic [LANES-1:0] pend;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_d;
    dir_e             pick_dir;

    // a lane is pending whenever its request disagrees with its up status
    assign pend     = lane_req ^ obuft_q;
    assign pick_dir = lane_req[pick_idx] ? UP : DN;
    assign rr_d     = (lane_q == IDX_W'(LANES - 1)) ? '0 : lane_q + 1'b1;

    rr_pick #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .pend_i  (pend),
        .rr_i    (rr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            lane_q  <= '0;
            gbuf_q  <= 1'b0;
            ibuf_q  <= '0;
            iddr_q  <= '0;
            obuft_q <= '0;
        end else if (kill) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gbuf_q  <= 1'b0;
            ibuf_q  <= '0;
            iddr_q  <= '0;
            obuft_q <= '0;
        end else begin
            gbuf_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (gbuf_q && pick_vld) begin
                        lane_q <= pick_idx;
                        unique case (pick_dir)
                            UP: begin
                                ibuf_q[pick_idx] <= 1'b1;
                                cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                                state_q <= UP_SETTLE;
                            end
                            DN: begin
                                obuft_q[pick_idx] <= 1'b0;
                                cnt_q   <= CNT_W'(FILL_CYCLES - 1);
                                state_q <= DN_DRAIN;
                            end
                        endcase
                    end
                end
                UP_SETTLE: begin
                    if (cnt_q == '0) begin
                        iddr_q[lane_q] <= 1'b1;
                        cnt_q   <= CNT_W'(FILL_CYCLES - 1);
                        state_q <= UP_FILL;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                UP_FILL: begin
                    if (cnt_q == '0) begin
                        obuft_q[lane_q] <= 1'b1;
                        rr_q    <= rr_d;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DN_DRAIN: begin
                    if (cnt_q == '0) begin
                        iddr_q[lane_q] <= 1'b0;
                        cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                        state_q <= DN_SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DN_SETTLE: begin
                    if (cnt_q == '0) begin
                        ibuf_q[lane_q] <= 1'b0;
                        rr_q    <= rr_d;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gbuf_en = gbuf_q;
    assign ibuf_en = ibuf_q;
    assign iddr_en = iddr_q;
    assign obuft_t = obuft_q;
    assign lane_up = obuft_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_io_lane_sequencer.sv
// Scoreboard bench: an event-schedule reference model predicts every cycle's
// outputs; a monitor compares them against the sequencer.
module tb_io_lane_sequencer;

    localparam int LANES = 3;
    localparam int S     = 4;
    localparam int F     = 2;

    typedef struct packed {
        logic             g;
        logic [LANES-1:0] ib;
        logic [LANES-1:0] id;
        logic [LANES-1:0] ob;
        logic [LANES-1:0] up;
        logic             busy;
    } obs_t;

    typedef struct {
        int at;
        int kind;
        int lane;
        bit val;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             kill = 1'b0;
    logic [LANES-1:0] lane_req = '0;
    logic             gbuf_en;
    logic [LANES-1:0] ibuf_en;
    logic [LANES-1:0] iddr_en;
    logic [LANES-1:0] obuft_t;
    logic [LANES-1:0] lane_up;
    logic             busy;

    int checks = 0;
    int failures = 0;

    io_lane_sequencer #(
        .LANES         (LANES),
        .SETTLE_CYCLES (S),
        .FILL_CYCLES   (F),
        .CNT_W         (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kill     (kill),
        .lane_req (lane_req),
        .gbuf_en  (gbuf_en),
        .ibuf_en  (ibuf_en),
        .iddr_en  (iddr_en),
        .obuft_t  (obuft_t),
        .lane_up  (lane_up),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    bit [LANES-1:0] m_ib, m_id, m_ob;
    bit             m_g;
    int             m_rr;
    int             cyc;
    int             free_at;
    ev_t            evq[$];
    obs_t           expq[$];

    // Reference model: on each edge, decide a pick from pre-edge state,
    // fire any scheduled events, and lay out the new lane's timeline.
    initial begin : model
        bit [LANES-1:0] pend;
        bit found;
        int k, j, t;
        m_ib = '0; m_id = '0; m_ob = '0; m_g = 0;
        m_rr = 0; cyc = 0; free_at = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_ib = '0; m_id = '0; m_ob = '0; m_g = 0;
                m_rr = 0; free_at = 0; evq.delete();
            end else if (kill) begin
                m_ib = '0; m_id = '0; m_ob = '0; m_g = 0;
                free_at = 0; evq.delete();
            end else begin
                pend = lane_req ^ m_ob;
                found = 0;
                k = 0;
                if (cyc >= free_at && m_g) begin
                    for (int i = 0; i < LANES; i++) begin
                        j = (m_rr + i) % LANES;
                        if (!found && pend[j]) begin
                            found = 1;
                            k = j;
                        end
                    end
                end
                for (int i = evq.size() - 1; i >= 0; i--) begin
                    if (evq[i].at == cyc + 1) begin
                        case (evq[i].kind)
                            0: m_ib[evq[i].lane] = evq[i].val;
                            1: m_id[evq[i].lane] = evq[i].val;
                            2: m_ob[evq[i].lane] = evq[i].val;
                            default: m_rr = evq[i].lane;
                        endcase
                        evq.delete(i);
                    end
                end
                m_g = 1;
                if (found) begin
                    t = cyc;
                    free_at = t + 1 + S + F;
                    if (lane_req[k]) begin
                        m_ib[k] = 1;
                        evq.push_back('{t + 1 + S, 1, k, 1'b1});
                        evq.push_back('{free_at, 2, k, 1'b1});
                    end else begin
                        m_ob[k] = 0;
                        evq.push_back('{t + 1 + F, 1, k, 1'b0});
                        evq.push_back('{free_at, 0, k, 1'b0});
                    end
                    evq.push_back('{free_at, 3, (k + 1) % LANES, 1'b0});
                end
            end
            cyc++;
            expq.push_back('{m_g, m_ib, m_id, m_ob, m_ob, (cyc < free_at)});
        end
    end

    initial begin : monitor
        obs_t got, exp_o;
        forever begin
            @(posedge clk);
            #2;
            got = '{gbuf_en, ibuf_en, iddr_en, obuft_t, lane_up, busy};
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                exp_o = expq.pop_front();
                if (got !== exp_o) begin
                    failures++;
                    $display("FAIL outputs t=%0t got g=%b ib=%b id=%b ob=%b up=%b busy=%b exp g=%b ib=%b id=%b ob=%b up=%b busy=%b",
                             $time, got.g, got.ib, got.id, got.ob, got.up, got.busy,
                             exp_o.g, exp_o.ib, exp_o.id, exp_o.ob, exp_o.up, exp_o.busy);
                end
            end
            checks++;
            if (((obuft_t & ~iddr_en) != '0) || ((iddr_en & ~ibuf_en) != '0) ||
                (lane_up !== obuft_t)) begin
                failures++;
                $display("FAIL invariants t=%0t ib=%b id=%b ob=%b up=%b",
                         $time, ibuf_en, iddr_en, obuft_t, lane_up);
            end
        end
    end

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while (!(cyc >= free_at && m_g && ((lane_req ^ m_ob) == '0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL wait_quiet timeout got=%0d cycles limit=%0d", n, budget);
        end
        @(negedge clk);
    endtask

    task automatic async_rst_check(input int settle);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({gbuf_en, ibuf_en, iddr_en, obuft_t, lane_up, busy} != '0) begin
            failures++;
            $display("FAIL async_rst got ib=%b id=%b ob=%b g=%b busy=%b exp all 0",
                     ibuf_en, iddr_en, obuft_t, gbuf_en, busy);
        end
        repeat (settle) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        lane_req = 3'b001;
        wait_quiet(100);

        lane_req = 3'b111;
        wait_quiet(100);
        lane_req = 3'b101;
        wait_quiet(100);

        lane_req = 3'b000;
        wait_quiet(100);
        lane_req = 3'b001;
        repeat (3) @(negedge clk);
        lane_req = 3'b000;
        wait_quiet(100);

        lane_req = 3'b101;
        wait_quiet(100);
        lane_req = 3'b111;
        repeat (3) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        wait_quiet(200);

        lane_req = 3'b000;
        wait_quiet(200);
        lane_req = 3'b001;
        repeat (6) @(negedge clk);
        async_rst_check(2);
        wait_quiet(100);

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                lane_req = LANES'($urandom_range(0, (1 << LANES) - 1));
            kill = ($urandom_range(0, 59) == 0);
            if (c == 400) begin
                kill = 1'b0;
                async_rst_check(1);
            end
        end
        kill = 1'b0;
        wait_quiet(200);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
